// File: rtl/mips_pkg.sv
// Shared MIPS datapath types used by the multiply/divide unit.
//   md_op_t    : operation select driven by the control unit on `op`
//   md_state_t : multiply/divide sequencer states
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One operation takes M+2 rising edges: capture, M iterations, sign fix/writeback.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          launch `op` using srcA/srcB (ignored while busy)
//   op             md_op_t: MULTU=00, MULT=01, DIVU=10, DIV=11
//   srcA, srcB     rs / rt operands
//   hiWe, loWe     MTHI / MTLO write enables (ignored while busy)
//   wrData         MTHI / MTLO data
//   busy           operation in progress
//   done           one-cycle pulse after HI/LO are written
//   hi, lo         HI / LO registers
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [M-1:0] srcA,
  input  logic [M-1:0] srcB,
  input  logic         hiWe,
  input  logic         loWe,
  input  logic [M-1:0] wrData,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] hi,
  output logic [M-1:0] lo
);

  localparam int CW = $clog2(M) + 1;

  md_state_t      state, state_nx;
  logic [CW-1:0]  cnt;
  logic [2*M-1:0] work;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [M-1:0]   opb;       // multiplicand or divisor (absolute value)
  logic           is_div_q;
  logic           neg_q;     // product/quotient negative
  logic           rem_neg_q; // remainder negative
  logic           div0_q;
  logic [M-1:0]   hi_q, lo_q;
  logic           done_q;

  // Operand preparation
  md_op_t       op_e;
  logic         signed_op, div_op, a_neg, b_neg;
  logic [M-1:0] abs_a, abs_b;

  always_comb begin
    op_e      = md_op_t'(op);
    signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    div_op    = (op_e == MD_DIVU) || (op_e == MD_DIV);
    a_neg     = signed_op & srcA[M-1];
    b_neg     = signed_op & srcB[M-1];
    // Negating the most negative value yields the same bit pattern, read as unsigned 2^(M-1).
    abs_a     = a_neg ? -srcA : srcA;
    abs_b     = b_neg ? -srcB : srcB;
  end

  // One iteration of each algorithm
  logic [M:0]     add_sum;
  logic [M:0]     rem_sh;
  logic [M+1:0]   diff;
  logic [2*M-1:0] work_mul, work_div;

  always_comb begin
    add_sum  = {1'b0, work[2*M-1:M]} + (work[0] ? {1'b0, opb} : '0);
    work_mul = {add_sum, work[M-1:1]};
    rem_sh   = work[2*M-1:M-1];
    diff     = {1'b0, rem_sh} - {2'b00, opb};
    // Restoring step: keep the shifted remainder when the trial subtract borrows.
    work_div = diff[M+1] ? {rem_sh[M-1:0], work[M-2:0], 1'b0}
                         : {diff[M-1:0],   work[M-2:0], 1'b1};
  end

  // Sign correction applied in FIX
  logic [2*M-1:0] prod_fix;
  logic [M-1:0]   work_lo, work_hi, quo_fix, rem_fix;

  always_comb begin
    work_lo  = work[M-1:0];
    work_hi  = work[2*M-1:M];
    prod_fix = neg_q ? -work : work;
    quo_fix  = div0_q ? '1 : (neg_q ? -work_lo : work_lo);
    // Divide by zero leaves |srcA| in the remainder; restoring its sign returns srcA itself.
    rem_fix  = rem_neg_q ? -work_hi : work_hi;
  end

  // Sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (start) state_nx = MD_RUN;
      MD_RUN:  if (cnt == CW'(1)) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      work      <= '0;
      opb       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == MD_FIX);
      case (state)
        MD_IDLE: begin
          if (hiWe) hi_q <= wrData;
          if (loWe) lo_q <= wrData;
          if (start) begin
            cnt       <= CW'(M);
            is_div_q  <= div_op;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= div_op && (srcB == '0);
            work      <= {{M{1'b0}}, (div_op ? abs_a : abs_b)};
            opb       <= div_op ? abs_b : abs_a;
          end
        end
        MD_RUN: begin
          work <= is_div_q ? work_div : work_mul;
          cnt  <= cnt - CW'(1);
        end
        MD_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*M-1:M];
            lo_q <= prod_fix[M-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each launched operation pushes its
// hand-computed {hi,lo} result; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int M = 32;

  logic         clk = 1'b0;
  logic         reset, start, hiWe, loWe;
  logic [1:0]   op;
  logic [M-1:0] srcA, srcB, wrData;
  logic         busy, done;
  logic [M-1:0] hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.M(M)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .hiWe   (hiWe),
    .loWe   (loWe),
    .wrData (wrData),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*M-1:0] exp_q[$];
  string          name_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    logic [2*M-1:0] e;
    string          nm;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with no pending operation", hi, lo);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_hilo"}, {hi, lo}, e);
        end
      end
    end
  end

  // Called at a negedge just after the start edge; returns at the negedge where done is seen.
  task automatic wait_done(input string name, output int busy_cycles);
    int cycles = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within 100 cycles, required by cycle %0d", name, M + 2);
    end
  endtask

  // Launch at a negedge with the DUT idle; optional same-edge MTHI.
  task automatic run_op(input string name, input logic [1:0] o, input logic [M-1:0] a,
                        input logic [M-1:0] b, input logic [M-1:0] exp_hi,
                        input logic [M-1:0] exp_lo, input bit hwe, input logic [M-1:0] wd);
    int bc;
    op = o; srcA = a; srcB = b; start = 1'b1;
    hiWe = hwe; wrData = wd;
    exp_q.push_back({exp_hi, exp_lo});
    name_q.push_back(name);
    @(negedge clk);
    start = 1'b0; hiWe = 1'b0;
    if (hwe) check({name, "_mthi_with_start"}, hi, wd);
    wait_done(name, bc);
    check({name, "_busy_cycles"}, bc, M + 1);
    check({name, "_busy_in_done_cycle"}, busy, 0);
  endtask

  initial begin
    int bc;
    reset = 1'b1; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    op = 2'b00; srcA = '0; srcB = '0; wrData = '0;
    #1;
    check("reset_state", {busy, done, hi, lo}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each next start lands in the previous done cycle.
    run_op("multu_7x6",   MD_MULTU, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, 1'b1, 32'h0000_1234);
    run_op("mult_m3x5",   MD_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, '0);
    run_op("mult_minsq",  MD_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, '0);
    run_op("multu_maxsq", MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, '0);
    run_op("div_m7d2",    MD_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, '0);
    run_op("divu_100d7",  MD_DIVU,  32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0, '0);
    run_op("divu_by0",    MD_DIVU,  32'h1234_5678,  32'd0,          32'h1234_5678, 32'hFFFF_FFFF, 1'b0, '0);
    run_op("div_m7by0",   MD_DIV,   32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, '0);
    run_op("div_ovf",     MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, '0);

    // start and MTHI while busy are ignored; hi still 0 from the previous op.
    op = MD_MULTU; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'h0000_000C});
    name_q.push_back("multu_3x4_ignore");
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    op = MD_DIVU; srcA = 32'd9; srcB = 32'd3; start = 1'b1;
    hiWe = 1'b1; wrData = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; hiWe = 1'b0;
    check("mthi_while_busy", hi, 32'h0000_0000);
    wait_done("multu_3x4_ignore", bc);
    @(negedge clk);
    check("no_second_op_after_ignored_start", busy, 0);

    // MTLO / MTHI in IDLE
    loWe = 1'b1; wrData = 32'h0000_BEEF;
    @(negedge clk);
    loWe = 1'b0;
    check("mtlo_idle", {hi, lo}, {32'h0000_0000, 32'h0000_BEEF});
    hiWe = 1'b1; wrData = 32'h0000_CAFE;
    @(negedge clk);
    hiWe = 1'b0;
    check("mthi_idle", {hi, lo}, {32'h0000_CAFE, 32'h0000_BEEF});

    // Reset mid-operation aborts with no writeback.
    op = MD_DIV; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_midop", {busy, done, hi, lo}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, hi, lo}, '0);
    run_op("multu_2x2_after_reset", MD_MULTU, 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 1'b0, '0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

endmodule
